xor_decrypt: RTL and testbench

XOR_DECRYPT -- requirements
Module: xor_decrypt

---
 rtl/xor_decrypt_pkg.sv | 19 +
 rtl/xor_out_stage.sv | 60 ++++++
 rtl/xor_decrypt.sv | 140 ++++++++++++++
 tb/tb_xor_decrypt.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_decrypt_pkg.sv
// Shared types and default sizing for the XOR decryptor.
// Optional checksum output is enabled with XOR_DECRYPT_CHKSUM_EN.
package xor_decrypt_pkg;

  localparam int MSG_SIZE_DEFAULT  = 8;
  localparam int KEY_WORDS_DEFAULT = 4;

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Key index width, never narrower than one bit so single-word keys still elaborate.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/xor_out_stage.sv
// One-entry registered output stage: holds data+last under a valid/ready handshake.
// Used by xor_decrypt; oSpace tells the upstream whether a word may be loaded this cycle.
module xor_out_stage
  import xor_decrypt_pkg::*;
#(
  parameter int WIDTH = MSG_SIZE_DEFAULT
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iData,
  input  logic             iLast,
  input  logic             iReady,
  output logic             oValid,
  output logic [WIDTH-1:0] oData,
  output logic             oLast,
  output logic             oTake,
  output logic             oSpace
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  assign oTake  = iEn & valid_q & iReady;
  assign oSpace = iEn & (~valid_q | iReady);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (iLoad) begin
      valid_d = 1'b1;
      data_d  = iData;
      last_d  = iLast;
    end else if (oTake) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    // NOTE: non-blocking assignments here so every register samples the pre-edge values.
    if (iRst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign oValid = valid_q;
  assign oData  = data_q;
  assign oLast  = last_q;

endmodule

// File: rtl/xor_decrypt.sv
// Streaming repeating-key XOR decryptor with key-load guard and message framing.
// Define XOR_DECRYPT_CHKSUM_EN to add the per-message plaintext checksum output oChecksum.
module xor_decrypt
  import xor_decrypt_pkg::*;
#(
  parameter int MSG_SIZE  = MSG_SIZE_DEFAULT,
  parameter int KEY_WORDS = KEY_WORDS_DEFAULT
) (
  input  logic                            iClk,
  input  logic                            iRst,
  input  logic                            iEn,
  input  logic                            iKey_Load,
  input  logic [MSG_SIZE*KEY_WORDS-1:0]   iKey_Assembled,
  input  logic                            iCipher_Valid,
  output logic                            oCipher_Ready,
  input  logic [MSG_SIZE-1:0]             iCiphertext,
  input  logic                            iLast,
  output logic                            oPlain_Valid,
  input  logic                            iPlain_Ready,
  output logic [MSG_SIZE-1:0]             oPlaintext,
  output logic                            oPlain_Last,
  output logic                            oDecrypt_flag,
  output logic                            oKey_Err
`ifdef XOR_DECRYPT_CHKSUM_EN
  ,
  output logic [MSG_SIZE-1:0]             oChecksum
`endif
);

  localparam int IDX_W = idx_width(KEY_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_WORDS - 1);

  state_e                                state_q, state_d;
  logic [KEY_WORDS-1:0][MSG_SIZE-1:0]    key_q, key_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic                                  key_err_q, key_err_d;

  logic                                  stage_space;
  logic                                  out_take;
  logic                                  in_xfer;
  logic                                  load_req;
  logic                                  load_ok;
  logic [MSG_SIZE-1:0]                   plain_word;

  assign oCipher_Ready = (state_q == RUN) & stage_space;
  assign in_xfer       = iCipher_Valid & oCipher_Ready;
  assign plain_word    = iCiphertext ^ key_q[idx_q];
  assign oDecrypt_flag = (state_q == DRAIN) & out_take;
  assign oKey_Err      = key_err_q;

  // A key swap is only safe on a message boundary with nothing in flight.
  assign load_req = iEn & iKey_Load;
  assign load_ok  = load_req &
                    ((state_q == NOKEY) |
                     ((state_q == RUN) & (idx_q == '0) & ~oPlain_Valid & ~in_xfer));

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    idx_d     = idx_q;
    key_err_d = load_req & ~load_ok;

    if (load_ok) begin
      key_d   = iKey_Assembled;
      idx_d   = '0;
      state_d = RUN;
    end

    if (in_xfer) begin
      if (iLast) begin
        idx_d   = '0;
        state_d = DRAIN;
      end else if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if ((state_q == DRAIN) && out_take) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= NOKEY;
      key_q     <= '0;
      idx_q     <= '0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      idx_q     <= idx_d;
      key_err_q <= key_err_d;
    end
  end

  xor_out_stage #(
    .WIDTH (MSG_SIZE)
  ) u_out_stage (
    .iClk   (iClk),
    .iRst   (iRst),
    .iEn    (iEn),
    .iLoad  (in_xfer),
    .iData  (plain_word),
    .iLast  (iLast),
    .iReady (iPlain_Ready),
    .oValid (oPlain_Valid),
    .oData  (oPlaintext),
    .oLast  (oPlain_Last),
    .oTake  (out_take),
    .oSpace (stage_space)
  );

`ifdef XOR_DECRYPT_CHKSUM_EN
  logic [MSG_SIZE-1:0] chk_q, chk_d;

  // Accumulates on input transfer; no input can arrive during the flag cycle (DRAIN).
  always_comb begin
    chk_d = chk_q;
    if (in_xfer) begin
      chk_d = chk_q ^ plain_word;
    end else if (oDecrypt_flag) begin
      chk_d = '0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign oChecksum = chk_q;
`endif

endmodule

// File: tb/tb_xor_decrypt.sv
// Directed scoreboard bench for xor_decrypt; checks oChecksum too when XOR_DECRYPT_CHKSUM_EN is defined.
module tb_xor_decrypt;

  localparam int MSG = 8;
  localparam int KW  = 4;

  logic              iClk = 1'b0;
  logic              iRst;
  logic              iEn;
  logic              iKey_Load;
  logic [MSG*KW-1:0] iKey_Assembled;
  logic              iCipher_Valid;
  logic              oCipher_Ready;
  logic [MSG-1:0]    iCiphertext;
  logic              iLast;
  logic              oPlain_Valid;
  logic              iPlain_Ready;
  logic [MSG-1:0]    oPlaintext;
  logic              oPlain_Last;
  logic              oDecrypt_flag;
  logic              oKey_Err;
`ifdef XOR_DECRYPT_CHKSUM_EN
  logic [MSG-1:0]    oChecksum;
`endif

  always #5 iClk = ~iClk;

  xor_decrypt #(
    .MSG_SIZE  (MSG),
    .KEY_WORDS (KW)
  ) dut (
    .iClk           (iClk),
    .iRst           (iRst),
    .iEn            (iEn),
    .iKey_Load      (iKey_Load),
    .iKey_Assembled (iKey_Assembled),
    .iCipher_Valid  (iCipher_Valid),
    .oCipher_Ready  (oCipher_Ready),
    .iCiphertext    (iCiphertext),
    .iLast          (iLast),
    .oPlain_Valid   (oPlain_Valid),
    .iPlain_Ready   (iPlain_Ready),
    .oPlaintext     (oPlaintext),
    .oPlain_Last    (oPlain_Last),
    .oDecrypt_flag  (oDecrypt_flag),
    .oKey_Err       (oKey_Err)
`ifdef XOR_DECRYPT_CHKSUM_EN
    ,
    .oChecksum      (oChecksum)
`endif
  );

  int             checks   = 0;
  int             failures = 0;
  logic [MSG:0]   sb[$];
  logic [MSG*KW-1:0] mkey;
  int             midx;
  bit             mkeyed;
  bit             mdrain;
  bit             accepted;
  bit             toggle_ready;
  int             flags;
  logic [MSG-1:0] chk_acc;
  logic [MSG-1:0] chk_final;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MSG-1:0] key_word(input int i);
    return mkey[i*MSG +: MSG];
  endfunction

  // One clock: compare at negedge against the model, then advance past the next rising edge.
  task automatic step();
    logic           exp_valid;
    logic           out_x;
    logic           flag_exp;
    logic [MSG-1:0] pw;
    @(negedge iClk);
    exp_valid = (sb.size() != 0);
    check("plain_valid", oPlain_Valid, exp_valid);
    out_x    = iEn && exp_valid && iPlain_Ready;
    flag_exp = out_x ? sb[0][MSG] : 1'b0;
    if (exp_valid) check("plain_word", {oPlain_Last, oPlaintext}, sb[0]);
    check("decrypt_flag", oDecrypt_flag, flag_exp);
    if (!mkeyed || mdrain || !iEn) check("cipher_ready_low", oCipher_Ready, 1'b0);
    else check("cipher_ready", oCipher_Ready, !exp_valid || iPlain_Ready);
`ifdef XOR_DECRYPT_CHKSUM_EN
    if (flag_exp) check("checksum", oChecksum, chk_final);
`endif
    if (oDecrypt_flag) flags++;
    if (out_x) begin
      if (sb[0][MSG]) mdrain = 1'b0;
      void'(sb.pop_front());
    end
    accepted = iCipher_Valid && oCipher_Ready;
    if (accepted) begin
      pw = iCiphertext ^ key_word(midx);
      sb.push_back({iLast, pw});
      chk_acc ^= pw;
      if (iLast) begin
        midx      = 0;
        mdrain    = 1'b1;
        chk_final = chk_acc;
        chk_acc   = '0;
      end else begin
        midx = (midx + 1) % KW;
      end
    end
    @(posedge iClk);
    #1;
    if (toggle_ready) iPlain_Ready = ~iPlain_Ready;
  endtask

  task automatic send_word(input logic [MSG-1:0] d, input logic last);
    iCipher_Valid = 1'b1;
    iCiphertext   = d;
    iLast         = last;
    accepted      = 1'b0;
    for (int n = 0; n < 20 && !accepted; n++) step();
    check("accept_timeout", accepted, 1'b1);
    iCipher_Valid = 1'b0;
    iLast         = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    check("drain_timeout", sb.size() == 0, 1'b1);
  endtask

  task automatic send_msg();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    send_word(8'h44, 1'b0);
    send_word(8'h55, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst = 1'b1; iEn = 1'b1; iKey_Load = 1'b0; iKey_Assembled = '0;
    iCipher_Valid = 1'b0; iCiphertext = '0; iLast = 1'b0; iPlain_Ready = 1'b1;
    mkey = '0; midx = 0; mkeyed = 1'b0; mdrain = 1'b0; toggle_ready = 1'b0;
    flags = 0; chk_acc = '0; chk_final = '0;
    @(posedge iClk);
    #1;
    step();
    check("rst_plaintext", oPlaintext, 8'h00);
    check("rst_last", oPlain_Last, 1'b0);
    check("rst_key_err", oKey_Err, 1'b0);
    iRst = 1'b0;

    // No key: valid input must never be accepted.
    iCipher_Valid = 1'b1; iCiphertext = 8'h11;
    for (int i = 0; i < 8; i++) step();
    iCipher_Valid = 1'b0;

    // Initial key load from NOKEY.
    iKey_Assembled = 32'h4433_2211; iKey_Load = 1'b1;
    step();
    iKey_Load = 1'b0;
    check("load_nokey_err", oKey_Err, 1'b0);
    mkey = 32'h4433_2211; mkeyed = 1'b1; midx = 0;

    // Full-throughput message.
    flags = 0;
    send_msg();
    drain();
    check("flag_count_stream", flags, 1);

    // Same message with downstream ready toggling every cycle.
    flags = 0; toggle_ready = 1'b1;
    send_msg();
    drain();
    toggle_ready = 1'b0; iPlain_Ready = 1'b1;
    check("flag_count_toggle", flags, 1);

    // Mid-message key load (idx=2) is rejected; the old key stays in use.
    flags = 0;
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    iKey_Assembled = 32'hAABB_CCDD; iKey_Load = 1'b1;
    step();
    iKey_Load = 1'b0;
    check("mid_load_err", oKey_Err, 1'b1);
    step();
    check("mid_load_err_pulse", oKey_Err, 1'b0);
    send_word(8'h33, 1'b0);
    send_word(8'h44, 1'b0);
    send_word(8'h55, 1'b1);
    drain();
    check("flag_count_mid", flags, 1);

    // Same load after the message completes is accepted.
    iKey_Load = 1'b1;
    step();
    iKey_Load = 1'b0;
    check("idle_load_err", oKey_Err, 1'b0);
    mkey = 32'hAABB_CCDD; midx = 0;
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b1);
    drain();

    // Load coinciding with an input transfer: old key used, load rejected.
    iKey_Assembled = 32'h1111_1111; iKey_Load = 1'b1;
    send_word(8'h10, 1'b0);
    iKey_Load = 1'b0;
    check("coincide_err", oKey_Err, 1'b1);
    send_word(8'h20, 1'b1);
    drain();

    // Load in DRAIN is rejected; iEn low freezes the held last word.
    iPlain_Ready = 1'b0; flags = 0;
    send_word(8'h5A, 1'b1);
    iKey_Load = 1'b1;
    step();
    iKey_Load = 1'b0;
    check("drain_load_err", oKey_Err, 1'b1);
    iPlain_Ready = 1'b1; iEn = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("en_low_no_flag", flags, 0);
    iEn = 1'b1;
    drain();
    check("flag_count_drain", flags, 1);

    // Reset while a word is held abandons it and requires a new key.
    iPlain_Ready = 1'b0;
    send_word(8'h77, 1'b0);
    step();
    iRst = 1'b1;
    step();
    sb.delete(); mkeyed = 1'b0; mdrain = 1'b0; midx = 0; chk_acc = '0;
    iRst = 1'b0; iPlain_Ready = 1'b1;
    check("post_rst_valid", oPlain_Valid, 1'b0);
    check("post_rst_plaintext", oPlaintext, 8'h00);
    check("post_rst_last", oPlain_Last, 1'b0);
    check("post_rst_ready", oCipher_Ready, 1'b0);
    check("post_rst_flag", oDecrypt_flag, 1'b0);
    check("post_rst_key_err", oKey_Err, 1'b0);
`ifdef XOR_DECRYPT_CHKSUM_EN
    check("post_rst_checksum", oChecksum, 8'h00);
`endif
    iCipher_Valid = 1'b1; iCiphertext = 8'h33;
    for (int i = 0; i < 5; i++) step();
    iCipher_Valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
